// File: rtl/pio_sw_responder_pkg.sv
// Shared types and constants for the single-wire PIO responder.
//   state_t    : responder FSM states
//   START_BIT  : line level of a start bit
//   STOP_BIT   : line level of a stop bit (also the released/idle level)
//   FRAME_BITS : start + 8 data + stop
//   max3       : elaboration-time helper used to size the shared timer
package pio_sw_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    WAIT_RESP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pio_sw_responder_if.sv
// Fabric-side request/response bundle of the PIO responder.
//   rx_data/rx_valid/rx_err : received request byte, update pulse, error pulse
//   resp_data/resp_valid    : response byte offered by the fabric
//   resp_ready              : responder accepts a response
//   busy                    : responder not idle
// master = fabric logic, slave = responder.
interface pio_sw_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, rx_err, resp_ready, busy,
    output resp_data, resp_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_err, resp_ready, busy,
    input  resp_data, resp_valid
  );
endinterface

// File: rtl/pio_sw_responder_bit_timer.sv
// Loadable down-counter shared by every responder state.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : cycles until expire, must be >= 1
//   expire     : one-cycle pulse exactly load_val cycles after the load cycle
module pio_sw_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Counter parks at zero, so expire fires once per load.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/pio_sw_responder.sv
// Half-duplex single-wire responder owning one bidirectional PIO pad.
// Receives a UART-style request byte, hands it to the fabric, takes a
// response byte over valid/ready, waits a turnaround, drives the response
// frame and releases the pad.
//   clk, rst_n   : clock, async active-low reset (releases the pad at once)
//   pad_i        : pad level from the buffer, asynchronous
//   pad_o, pad_t : buffer drive level and tristate (pad_t=1 released)
//   fab          : fabric request/response bundle (slave side)
module pio_sw_responder
  import pio_sw_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TURNAROUND   = 32,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pad_i,
  output logic                pad_o,
  output logic                pad_t,
  pio_sw_responder_if.slave   fab
);

  localparam int TW = $clog2(max3(CLKS_PER_BIT, TURNAROUND, RESP_TIMEOUT) + 1);
  localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] BIT_T    = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] TURN_T   = TW'(TURNAROUND);
  localparam logic [TW-1:0] TMO_T    = TW'(RESP_TIMEOUT);
  localparam logic [2:0]    LAST_BIT = 3'(FRAME_BITS - 3);

  state_t        state, state_d;
  logic          s_meta, s;
  logic          armed;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          resp_ready_q, busy_q;
  logic          pad_o_d, pad_t_d;
  logic          tmr_load, tmr_exp;
  logic [TW-1:0] tmr_val;

  pio_sw_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  // Two-flop synchronizer; resets to the idle (pulled-up) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= pad_i;
      s      <= s_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      bit_idx      <= 3'd0;
      pad_o        <= STOP_BIT;
      pad_t        <= 1'b1;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_d;
      // Only a high level observed while idle arms the edge detector, so
      // our own frame (seen while not idle) can never start a reception.
      armed        <= (state == IDLE) && (s == STOP_BIT);
      bit_idx      <= bit_d;
      pad_o        <= pad_o_d;
      pad_t        <= pad_t_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_err_q     <= rx_err_d;
      resp_ready_q <= (state_d == WAIT_RESP);
      busy_q       <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    rx_sh <= rx_sh_d;
    tx_sh <= tx_sh_d;
  end

  always_comb begin
    state_d    = state;
    tmr_load   = 1'b0;
    tmr_val    = BIT_T;
    bit_d      = bit_idx;
    rx_sh_d    = rx_sh;
    tx_sh_d    = tx_sh;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    pad_o_d    = pad_o;
    pad_t_d    = pad_t;

    case (state)
      IDLE: begin
        pad_o_d = STOP_BIT;
        pad_t_d = 1'b1;
        if (armed && (s == START_BIT)) begin
          state_d  = RX_START;
          tmr_load = 1'b1;
          tmr_val  = HALF_T;
        end
      end
      RX_START: if (tmr_exp) begin
        if (s == STOP_BIT) begin
          state_d = IDLE;
        end else begin
          state_d  = RX_DATA;
          tmr_load = 1'b1;
          bit_d    = 3'd0;
        end
      end
      RX_DATA: if (tmr_exp) begin
        rx_sh_d  = {s, rx_sh[7:1]};
        bit_d    = bit_idx + 3'd1;
        tmr_load = 1'b1;
        if (bit_idx == LAST_BIT) state_d = RX_STOP;
      end
      RX_STOP: if (tmr_exp) begin
        if (s == STOP_BIT) begin
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
          state_d    = WAIT_RESP;
          tmr_load   = 1'b1;
          tmr_val    = TMO_T;
        end else begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_RESP: begin
        // A handshake in the last timeout cycle still wins.
        if (fab.resp_valid && fab.resp_ready) begin
          tx_sh_d  = fab.resp_data;
          state_d  = TURN;
          tmr_load = 1'b1;
          tmr_val  = TURN_T;
        end else if (tmr_exp) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      TURN: if (tmr_exp) begin
        state_d  = TX_START;
        tmr_load = 1'b1;
        pad_t_d  = 1'b0;
        pad_o_d  = START_BIT;
      end
      TX_START: if (tmr_exp) begin
        state_d  = TX_DATA;
        tmr_load = 1'b1;
        bit_d    = 3'd0;
        pad_o_d  = tx_sh[0];
        tx_sh_d  = {1'b0, tx_sh[7:1]};
      end
      TX_DATA: if (tmr_exp) begin
        tmr_load = 1'b1;
        bit_d    = bit_idx + 3'd1;
        if (bit_idx == LAST_BIT) begin
          state_d = TX_STOP;
          pad_o_d = STOP_BIT;
        end else begin
          pad_o_d = tx_sh[0];
          tx_sh_d = {1'b0, tx_sh[7:1]};
        end
      end
      TX_STOP: if (tmr_exp) begin
        state_d = IDLE;
        pad_t_d = 1'b1;
        pad_o_d = STOP_BIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fab.rx_data    = rx_data_q;
  assign fab.rx_valid   = rx_valid_q;
  assign fab.rx_err     = rx_err_q;
  assign fab.resp_ready = resp_ready_q;
  assign fab.busy       = busy_q;

endmodule

// File: tb/tb_pio_sw_responder.sv
// Scoreboard bench for pio_sw_responder: the stimulus pushes expected
// receive events and expected transmitted bytes; independent monitors pop
// and compare whenever the responder reports or drives the pad.
module tb_pio_sw_responder;
  import pio_sw_pkg::*;

  localparam int CPB = 8;
  localparam int TA  = 16;
  localparam int TO  = 64;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } rx_ev_t;

  logic clk, rst_n, pad_i, pad_o, pad_t, host_drv, abort_tx;
  int   n_cmp, n_bad, cyc, hs_cyc, rr_len;
  logic rr_hs;
  rx_ev_t rx_q[$];
  logic [7:0] tx_q[$];
  rx_ev_t ev_r;

  pio_sw_responder_if fab();

  pio_sw_responder #(
    .CLKS_PER_BIT (CPB),
    .TURNAROUND   (TA),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pad_i (pad_i),
    .pad_o (pad_o),
    .pad_t (pad_t),
    .fab   (fab)
  );

  // Pad with pull-up: host drives only while the responder has released it.
  assign pad_i = pad_t ? host_drv : pad_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, d, START_BIT};
    @(posedge clk); #1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      host_drv = f[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    host_drv = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (fab.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_busy", fab.busy, 1'b0);
  endtask

  // Receive-event monitor.
  always @(negedge clk) begin
    if (rst_n && (fab.rx_valid || fab.rx_err)) begin
      check("rx_valid_err_exclusive", fab.rx_valid & fab.rx_err, 1'b0);
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_unexpected: got valid=%0b err=%0b data=%02h, expected no event",
                 fab.rx_valid, fab.rx_err, fab.rx_data);
      end else begin
        ev_r = rx_q.pop_front();
        check("rx_kind_is_err", fab.rx_err, ev_r.is_err);
        if (!ev_r.is_err) check("rx_data", fab.rx_data, ev_r.data);
      end
    end
  end

  // resp_ready window monitor: records handshakes, checks timeout length.
  always @(negedge clk) begin
    if (!rst_n) begin
      rr_len = 0;
      rr_hs  = 1'b0;
    end else if (fab.resp_ready) begin
      rr_len++;
      if (fab.resp_valid) begin
        rr_hs  = 1'b1;
        hs_cyc = cyc;
      end
    end else if (rr_len != 0) begin
      if (!rr_hs) check("resp_timeout_len", rr_len, TO);
      rr_len = 0;
      rr_hs  = 1'b0;
    end
  end

  // Transmit monitor: one pass per pad drive episode.
  initial begin : tx_mon
    int n;
    logic [9:0] bits;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_n && !pad_t) begin
        // pad_t falls on the TA-th clock edge after the handshake edge.
        check("tx_turnaround", cyc - hs_cyc, TA + 1);
        n = 0;
        bits = '1;
        while (!pad_t && n < 200) begin
          if ((n % CPB) == (CPB / 2) && (n / CPB) < FRAME_BITS) bits[n / CPB] = pad_o;
          n++;
          @(negedge clk);
        end
        if (abort_tx) begin
          check("tx_abort_short", n < FRAME_BITS * CPB, 1'b1);
        end else if (tx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got frame %03h driven, expected pad released", bits);
        end else begin
          exp_b = tx_q.pop_front();
          check("tx_low_len", n, FRAME_BITS * CPB);
          check("tx_frame", bits, {STOP_BIT, exp_b, START_BIT});
        end
      end
    end
  end

  initial begin
    int k;
    n_cmp = 0;
    n_bad = 0;
    hs_cyc = 0;
    rst_n = 1'b0;
    host_drv = 1'b1;
    abort_tx = 1'b0;
    fab.resp_valid = 1'b0;
    fab.resp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pad_t", pad_t, 1'b1);
    check("rst_pad_o", pad_o, 1'b1);
    check("rst_rx_data", fab.rx_data, 8'h00);
    check("rst_rx_valid", fab.rx_valid, 1'b0);
    check("rst_rx_err", fab.rx_err, 1'b0);
    check("rst_resp_ready", fab.resp_ready, 1'b0);
    check("rst_busy", fab.busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean request, response already offered.
    rx_q.push_back('{1'b0, 8'hA5});
    tx_q.push_back(8'h3C);
    fab.resp_data = 8'h3C;
    fab.resp_valid = 1'b1;
    send_frame(8'hA5, 1'b1);
    wait_idle(400);
    fab.resp_valid = 1'b0;
    @(negedge clk);
    check("s1_pad_t_after", pad_t, 1'b1);
    check("s1_pad_o_after", pad_o, 1'b1);
    check("s1_rx_data_hold", fab.rx_data, 8'hA5);

    // Framing error: stop bit held low.
    rx_q.push_back('{1'b1, 8'h00});
    send_frame(8'h00, 1'b0);
    wait_idle(100);
    repeat (4) @(negedge clk);
    check("s2_rx_data_unchanged", fab.rx_data, 8'hA5);
    check("s2_pad_t", pad_t, 1'b1);
    check("s2_busy", fab.busy, 1'b0);

    // Short low glitch on the idle line.
    @(posedge clk); #1;
    host_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    host_drv = 1'b1;
    repeat (8) @(negedge clk);
    check("s3_busy_after_glitch", fab.busy, 1'b0);

    // No response offered: timeout.
    fab.resp_valid = 1'b0;
    rx_q.push_back('{1'b0, 8'hC3});
    rx_q.push_back('{1'b1, 8'h00});
    send_frame(8'hC3, 1'b1);
    wait_idle(400);
    @(negedge clk);
    check("s4_resp_ready_low", fab.resp_ready, 1'b0);
    check("s4_pad_t", pad_t, 1'b1);

    // Reset during data bit 4 of the response (0x86: bit 4 is 0).
    rx_q.push_back('{1'b0, 8'h69});
    fab.resp_data = 8'h86;
    fab.resp_valid = 1'b1;
    abort_tx = 1'b1;
    send_frame(8'h69, 1'b1);
    k = 0;
    while (pad_t && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("s5_tx_started", pad_t, 1'b0);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    check("s5_pre_rst_pad_t", pad_t, 1'b0);
    check("s5_pre_rst_bit4", pad_o, 1'b0);
    #1;
    rst_n = 1'b0;
    fab.resp_valid = 1'b0;
    #1;
    check("s5_rst_pad_t", pad_t, 1'b1);
    check("s5_rst_pad_o", pad_o, 1'b1);
    check("s5_rst_busy", fab.busy, 1'b0);
    check("s5_rst_rx_data", fab.rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    abort_tx = 1'b0;
    repeat (4) @(negedge clk);
    rx_q.push_back('{1'b0, 8'h5A});
    tx_q.push_back(8'h24);
    fab.resp_data = 8'h24;
    fab.resp_valid = 1'b1;
    send_frame(8'h5A, 1'b1);
    wait_idle(400);
    fab.resp_valid = 1'b0;
    check("s5_rx_data_after", fab.rx_data, 8'h5A);

    // Back-to-back requests, each answered.
    rx_q.push_back('{1'b0, 8'h11});
    tx_q.push_back(8'hE1);
    fab.resp_data = 8'hE1;
    fab.resp_valid = 1'b1;
    send_frame(8'h11, 1'b1);
    wait_idle(400);
    rx_q.push_back('{1'b0, 8'h22});
    tx_q.push_back(8'hE2);
    fab.resp_data = 8'hE2;
    send_frame(8'h22, 1'b1);
    wait_idle(400);
    fab.resp_valid = 1'b0;
    check("s6_rx_data_last", fab.rx_data, 8'h22);

    repeat (20) @(negedge clk);
    check("rx_queue_drained", rx_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_sw_responder.md
# pio_sw_responder

Half-duplex single-wire responder that owns one bidirectional PIO pad. It listens on the tristated pad for a UART-style request frame and hands the received byte to fabric logic. It then takes a response byte over a valid/ready handshake, waits a bus turnaround, drives the response frame onto the pad, and releases the pad. It sits between the fabric and the pad's bidirectional buffer, using the `I`/`O`/`T` pins (`T`=1 tristates). It is the far-end counterpart of the pad-driving initiator logic used in the IO timing designs.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 4.
- `TURNAROUND`, 32: idle cycles between accepting the response and driving its start bit; legal range ≥ 1.
- `RESP_TIMEOUT`, 1024: maximum cycles spent in `WAIT_RESP` before the request is abandoned.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pad_i` in 1: buffer output (pad level), asynchronous to `clk`.
- `pad_o` out 1: drive level to the buffer.
- `pad_t` out 1: tristate control (1 = released/high-Z).
- `rx_data` out 8: last received request byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` is updated.
- `rx_err` out 1: one-cycle pulse on framing error or response timeout.
- `resp_data` in 8: response byte.
- `resp_valid` in 1: response offered.
- `resp_ready` out 1: high only in `WAIT_RESP`; transfer happens when `resp_valid & resp_ready`.
- `busy` out 1: high in every state except `IDLE`.

## Operation
- `pad_i` passes through a 2-FF synchronizer; all sampling uses its output `s`. The pad idles high via the external pull-up.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1), each bit `CLKS_PER_BIT` cycles long.
- **IDLE**: on a falling edge of `s`, load the half-bit count and go to `RX_START`.
- **RX_START**: at mid-bit, if `s`=1 (glitch) return to `IDLE` silently; otherwise go to `RX_DATA`.
- **RX_DATA**: sample `s` every `CLKS_PER_BIT` at mid-bit into the shift register. After the 8th bit, go to `RX_STOP`.
- **RX_STOP**: sample at mid-bit.
  - `s`=1: update `rx_data`, pulse `rx_valid`, go to `WAIT_RESP`.
  - `s`=0: pulse `rx_err`, leave `rx_data` unchanged, go to `IDLE`.
- **WAIT_RESP**: `resp_ready`=1.
  - On handshake: latch `resp_data` and go to `TURN`.
  - After `RESP_TIMEOUT` cycles without a handshake: pulse `rx_err` and go to `IDLE`.
  - Pad activity is ignored in this state.
- **TURN**: count `TURNAROUND` cycles, then go to `TX_START`.
- **TX_START / TX_DATA / TX_STOP**: drive 0, then the 8 bits LSB first, then 1, each for a full bit. `pad_t`=0 throughout. At the end of the stop bit, set `pad_t`=1 and `pad_o`=1 and go to `IDLE`.
- The falling-edge detector is re-armed only after `s` has been seen at 1 in `IDLE`, so the block never answers its own frame.
- Asserting `rst_n` low in any state, including mid-transmit, immediately releases the pad (`pad_t`=1). An in-flight frame is discarded.

## Timing
- Reset values:
  - `pad_t`=1, `pad_o`=1
  - `rx_data`=0x00, `rx_valid`=0, `rx_err`=0
  - `resp_ready`=0, `busy`=0
  - synchronizer flops=1
- All outputs are registered.
- Input latency: a pad edge reaches `s` after 2 clocks.
- Mid-bit sample points fall `CLKS_PER_BIT/2` (integer divide) cycles after the detected edge, then every `CLKS_PER_BIT` cycles.
- `rx_valid` is asserted in the cycle after the stop-bit sample; `resp_ready` rises in that same cycle.
- If `resp_valid` is already high when `resp_ready` rises, the handshake completes in that cycle.
- `pad_t` falls exactly `TURNAROUND` cycles after the handshake cycle, and stays low for exactly 10×`CLKS_PER_BIT` cycles.
- `rx_valid` and `rx_err` never assert in the same cycle.

## Structure
- Package `pio_sw_pkg` holds:
  - the state enum (`IDLE, RX_START, RX_DATA, RX_STOP, WAIT_RESP, TURN, TX_START, TX_DATA, TX_STOP`)
  - the `START_BIT`/`STOP_BIT` level constants
  - the frame length constant (10)
- Sub-module `pio_sw_bit_timer`: a loadable down-counter of width `$clog2(max(CLKS_PER_BIT, TURNAROUND, RESP_TIMEOUT)+1)` with a one-cycle `expire` output. It is shared by all states.
- The bit index is a 3-bit counter; it wraps after bit 7.

## Test plan
Bench settings for all scenarios: `CLKS_PER_BIT`=8, `TURNAROUND`=16, `RESP_TIMEOUT`=64.
- Clean request 0xA5 on `pad_i`, `resp_valid` held high with 0x3C → one `rx_valid` pulse with `rx_data`=0xA5. `pad_t` falls 16 cycles after the handshake and the pad carries 0,0,0,1,1,1,1,0,0,1 at 8 cycles each. `pad_t`=1 afterwards.
- Request 0x00 with the stop bit forced low → `rx_err` pulses once, no `rx_valid`, `rx_data` unchanged, `pad_t` stays 1, back to `IDLE`.
- 3-cycle low glitch on idle `pad_i` → no `rx_valid`, no `rx_err`, `busy` returns to 0 within 8 cycles.
- Valid request, `resp_valid` held low → `resp_ready` high for 64 cycles, then `rx_err` pulses, `resp_ready`=0, the pad is never driven.
- `rst_n` asserted during TX bit 4 → `pad_t`=1 and `pad_o`=1 in the same cycle. After release, a new request 0x5A is received correctly.
- Back-to-back requests 0x11 then 0x22, each answered → both `rx_valid` pulses with the correct data. The block's own transmitted frame never produces an `rx_valid`.
